// File: rtl/int_flag_pkg.sv
// Shared types for the interrupt flag save/restore controller.
package int_flag_pkg;

   // Controller FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      RESTORE = 2'd2
   } state_e;

   // One saved flag pair.
   typedef struct packed {
      logic c;
      logic z;
   } flags_t;

endpackage

// File: rtl/int_flag_ctrl_flag_lifo.sv
// flag_lifo: small LIFO of saved {C,Z} pairs with stack pointer and
// full/empty status. Push and pop are only ever requested one at a time.
module flag_lifo
   import int_flag_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SP_W  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            push_i,
   input  logic            pop_i,
   input  flags_t          wdata_i,
   output flags_t          rdata_o,
   output logic [SP_W-1:0] sp_o,
   output logic            full_o,
   output logic            empty_o
);

   flags_t          mem [DEPTH];
   logic [SP_W-1:0] sp_q;
   logic [SP_W-1:0] sp_d;

   assign sp_o    = sp_q;
   assign full_o  = (sp_q == SP_W'(DEPTH));
   assign empty_o = (sp_q == '0);

   // Next stack pointer: grow on push, shrink on pop, saturating at the ends.
   always_comb begin
      // NOTE: default first so every path assigns sp_d and no latch is inferred.
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - 1'b1;
      end
   end

   // Stack pointer register, frozen while the global enable is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: non-blocking assignments for all flop state, so every flop
         // samples pre-edge values regardless of process ordering.
         sp_q <= '0;
      end else if (en) begin
         sp_q <= sp_d;
      end
   end

   // Storage write at the current top; contents are meaningless until pushed.
   // NOTE: the storage array deliberately has no reset; only sp decides what is valid.
   always_ff @(posedge clk) begin
      if (en && push_i && !full_o) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i)) begin
               mem[i] <= wdata_i;
            end
         end
      end
   end

   // Top-of-stack read (entry sp-1); zero when empty.
   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) begin
            rdata_o = mem[i];
         end
      end
   end

endmodule

// File: rtl/int_flag_ctrl.sv
// int_flag_ctrl: saves C/Z on interrupt entry and restores them through the
// flag register's interrupt write port on return-from-interrupt.
// Build option: define INT_NEST_EN to allow nesting up to DEPTH levels;
// otherwise only a single level is stored and an irq inside an ISR waits.
module int_flag_ctrl
   import int_flag_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int SP_W  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clock_en,
   input  logic            int_en_i,
   input  logic            irq_i,
   input  logic            reti_i,
   input  logic            c_i,
   input  logic            z_i,
   output logic            irq_ack_o,
   output logic            iwe_o,
   output logic            intc_o,
   output logic            intz_o,
   output logic            in_isr_o,
   output logic [SP_W-1:0] depth_o,
   output logic            ovf_o,
   output logic            unf_o
);

`ifdef INT_NEST_EN
   localparam int LIFO_DEPTH = DEPTH;
`else
   localparam int LIFO_DEPTH = 1;
`endif

   state_e state_q;
   state_e state_d;

   logic   push;
   logic   pop;
   logic   nest_ok;
   logic   lifo_full;
   logic   lifo_empty;
   flags_t top_flags;
   flags_t cur_flags;

   logic   irq_ack_q, irq_ack_d;
   logic   iwe_q,     iwe_d;
   logic   intc_q,    intc_d;
   logic   intz_q,    intz_d;
   logic   ovf_q,     ovf_d;
   logic   unf_q,     unf_d;

   assign cur_flags = '{c: c_i, z: z_i};

`ifdef INT_NEST_EN
   assign nest_ok = !lifo_full;
`else
   // Single level: accept only outside any ISR.
   assign nest_ok = lifo_empty && !lifo_full;
`endif

   flag_lifo #(
      .DEPTH (LIFO_DEPTH),
      .SP_W  (SP_W)
   ) u_lifo (
      .clk     (clk),
      .rst     (rst),
      .en      (clock_en),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (cur_flags),
      .rdata_o (top_flags),
      .sp_o    (depth_o),
      .full_o  (lifo_full),
      .empty_o (lifo_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else if (clock_en) begin
         state_q <= state_d;
      end
   end

   // Next state plus stack push/pop; reti has priority over irq in IDLE.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (reti_i) begin
               if (!lifo_empty) begin
                  pop     = 1'b1;
                  state_d = RESTORE;
               end
            end else if (irq_i && int_en_i && nest_ok) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         RESTORE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered-output next values; sticky error flags only ever set.
   always_comb begin
      irq_ack_d = (state_d == ACK);
      iwe_d     = (state_d == RESTORE);
      intc_d    = iwe_d ? top_flags.c : 1'b0;
      intz_d    = iwe_d ? top_flags.z : 1'b0;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      if (state_q == IDLE) begin
         if (reti_i && lifo_empty) begin
            unf_d = 1'b1;
         end
`ifdef INT_NEST_EN
         if (!reti_i && irq_i && int_en_i && lifo_full) begin
            ovf_d = 1'b1;
         end
`endif
      end
   end

   // Output registers, frozen with the global enable so pulses stretch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_ack_q <= 1'b0;
         iwe_q     <= 1'b0;
         intc_q    <= 1'b0;
         intz_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else if (clock_en) begin
         irq_ack_q <= irq_ack_d;
         iwe_q     <= iwe_d;
         intc_q    <= intc_d;
         intz_q    <= intz_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign irq_ack_o = irq_ack_q;
   assign iwe_o     = iwe_q;
   assign intc_o    = intc_q;
   assign intz_o    = intz_q;
   assign ovf_o     = ovf_q;
   assign unf_o     = unf_q;
   assign in_isr_o  = (depth_o != '0);

endmodule

// File: tb/tb_int_flag_ctrl.sv
// Testbench for int_flag_ctrl: directed stimulus pushes expected ack/restore
// events into a scoreboard queue; a negedge monitor pops and compares each
// new ack or flag-write pulse. Latency and status outputs are checked inline.
module tb_int_flag_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clock_en = 1'b1;
   logic       int_en_i = 1'b1;
   logic       irq_i = 1'b0;
   logic       reti_i = 1'b0;
   logic       c_i = 1'b0;
   logic       z_i = 1'b0;
   logic       irq_ack_o;
   logic       iwe_o;
   logic       intc_o;
   logic       intz_o;
   logic       in_isr_o;
   logic [2:0] depth_o;
   logic       ovf_o;
   logic       unf_o;

   typedef struct {
      bit is_ack;
      bit c;
      bit z;
      int depth;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int_flag_ctrl #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .clock_en  (clock_en),
      .int_en_i  (int_en_i),
      .irq_i     (irq_i),
      .reti_i    (reti_i),
      .c_i       (c_i),
      .z_i       (z_i),
      .irq_ack_o (irq_ack_o),
      .iwe_o     (iwe_o),
      .intc_o    (intc_o),
      .intz_o    (intz_o),
      .in_isr_o  (in_isr_o),
      .depth_o   (depth_o),
      .ovf_o     (ovf_o),
      .unf_o     (unf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle irq from IDLE; expects an ack the next cycle, then back to IDLE.
   task automatic do_irq(input bit c, input bit z, input int depth_after);
      c_i   = c;
      z_i   = z;
      irq_i = 1'b1;
      exp_q.push_back('{is_ack: 1'b1, c: 1'b0, z: 1'b0, depth: depth_after});
      step(1);
      irq_i = 1'b0;
      check("ack_latency", irq_ack_o, 1);
      step(1);
      check("ack_one_cycle", irq_ack_o, 0);
   endtask

   // One-cycle reti from IDLE while live flags differ from the saved ones.
   task automatic do_reti(input bit c, input bit z, input int depth_after);
      c_i    = ~c;
      z_i    = ~z;
      reti_i = 1'b1;
      exp_q.push_back('{is_ack: 1'b0, c: c, z: z, depth: depth_after});
      step(1);
      reti_i = 1'b0;
      check("iwe_latency", iwe_o, 1);
      step(1);
      check("iwe_one_cycle", {iwe_o, intc_o, intz_o}, 0);
   endtask

   // Scoreboard monitor: compare each new output pulse with the queue head.
   initial begin : monitor
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if ((irq_ack_o || iwe_o) && !prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse",
                     {24'd0, irq_ack_o, iwe_o, intc_o, intz_o, 1'b0, depth_o}, 0);
            end else begin
               e = exp_q.pop_front();
               check("mon_event",
                     {24'd0, irq_ack_o, iwe_o, intc_o, intz_o, 1'b0, depth_o},
                     {24'd0, e.is_ack, !e.is_ack, e.c, e.z, 1'b0, 3'(e.depth)});
            end
         end
         prev = irq_ack_o || iwe_o;
      end
   end

   initial begin : stimulus
      // Reset values
      step(2);
      check("rst_ack",   irq_ack_o, 0);
      check("rst_iwe",   iwe_o, 0);
      check("rst_depth", depth_o, 0);
      check("rst_isr",   in_isr_o, 0);
      check("rst_ovf",   ovf_o, 0);
      check("rst_unf",   unf_o, 0);
      rst = 1'b1;
      step(1);

      // Async reset while ack is high
      c_i   = 1'b1;
      z_i   = 1'b1;
      irq_i = 1'b1;
      exp_q.push_back('{is_ack: 1'b1, c: 1'b0, z: 1'b0, depth: 1});
      step(1);
      irq_i = 1'b0;
      check("mid_ack_high", irq_ack_o, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("mid_ack_rst_ack",   irq_ack_o, 0);
      check("mid_ack_rst_depth", depth_o, 0);
      check("mid_ack_rst_isr",   in_isr_o, 0);
      step(1);
      rst = 1'b1;
      step(1);

      // Basic save and restore
      do_irq(1'b1, 1'b0, 1);
      check("basic_depth1", depth_o, 1);
      check("basic_isr",    in_isr_o, 1);
      do_reti(1'b1, 1'b0, 0);
      check("basic_depth0", depth_o, 0);

      // Interrupts disabled: no push
      int_en_i = 1'b0;
      irq_i    = 1'b1;
      step(2);
      check("inten_no_ack", irq_ack_o, 0);
      check("inten_depth",  depth_o, 0);
      irq_i    = 1'b0;
      int_en_i = 1'b1;
      step(1);

      // Underflow: reti with empty stack
      reti_i = 1'b1;
      step(1);
      reti_i = 1'b0;
      check("unf_set",   unf_o, 1);
      check("unf_iwe",   iwe_o, 0);
      check("unf_depth", depth_o, 0);

      // Simultaneous irq and reti at depth 1: restore first, then ack
      do_irq(1'b1, 1'b0, 1);
      c_i    = 1'b0;
      z_i    = 1'b1;
      irq_i  = 1'b1;
      reti_i = 1'b1;
      exp_q.push_back('{is_ack: 1'b0, c: 1'b1, z: 1'b0, depth: 0});
      exp_q.push_back('{is_ack: 1'b1, c: 1'b0, z: 1'b0, depth: 1});
      step(1);
      reti_i = 1'b0;
      check("sim_iwe",    iwe_o, 1);
      check("sim_no_ack", irq_ack_o, 0);
      step(1);
      check("sim_gap", {irq_ack_o, iwe_o}, 0);
      c_i = 1'b1;
      z_i = 1'b0;
      step(1);
      irq_i = 1'b0;
      check("sim_ack",   irq_ack_o, 1);
      check("sim_depth", depth_o, 1);
      step(1);
      do_reti(1'b1, 1'b0, 0);

      // Clock enable low during RESTORE stretches the write pulse
      do_irq(1'b0, 1'b1, 1);
      c_i    = 1'b1;
      z_i    = 1'b0;
      reti_i = 1'b1;
      exp_q.push_back('{is_ack: 1'b0, c: 1'b0, z: 1'b1, depth: 0});
      step(1);
      reti_i   = 1'b0;
      clock_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("cen_hold", {iwe_o, intc_o, intz_o, 1'b0, depth_o}, 7'b101_0000);
      end
      clock_en = 1'b1;
      step(1);
      check("cen_release", iwe_o, 0);

`ifdef INT_NEST_EN
      // Nesting to full depth, overflow, then unwind in LIFO order
      do_irq(1'b1, 1'b1, 1);
      do_irq(1'b0, 1'b1, 2);
      do_irq(1'b1, 1'b0, 3);
      do_irq(1'b0, 1'b0, 4);
      irq_i = 1'b1;
      step(3);
      check("ovf_no_ack", irq_ack_o, 0);
      check("ovf_set",    ovf_o, 1);
      check("ovf_depth",  depth_o, 4);
      irq_i = 1'b0;
      step(1);
      do_reti(1'b0, 1'b0, 3);
      do_reti(1'b1, 1'b0, 2);
      do_reti(1'b0, 1'b1, 1);
      do_reti(1'b1, 1'b1, 0);
`else
      // Single level: irq inside an ISR waits and does not flag overflow
      do_irq(1'b1, 1'b1, 1);
      c_i   = 1'b0;
      z_i   = 1'b0;
      irq_i = 1'b1;
      step(3);
      check("nonest_no_ack", irq_ack_o, 0);
      check("nonest_ovf",    ovf_o, 0);
      check("nonest_depth",  depth_o, 1);
      irq_i = 1'b0;
      step(1);
      do_reti(1'b1, 1'b1, 0);
`endif

      step(3);
      check("sb_drained", exp_q.size(), 0);
      check("unf_sticky", unf_o, 1);
      check("end_isr",    in_isr_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
